audio_level_meter: RTL and testbench

AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

---
 rtl/audio_pkg.sv | 18 +
 rtl/level_encoder.sv | 38 +++
 rtl/audio_level_meter.sv | 98 +++++++++
 tb/tb_audio_level_meter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio level meter.
// Default tuning, level geometry and FSM state codes.
package audio_pkg;

  localparam int MIDPOINT_DEF    = 2048;
  localparam int WINDOW_DEF      = 4000;
  localparam int THRESH_STEP_DEF = 224;

  localparam int LEVELS = 9;
  localparam int LVL_W  = 4;

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  typedef logic [LVL_W-1:0]  level_t;
  typedef logic [LEVELS-1:0] bar_t;

endpackage

// File: rtl/level_encoder.sv
// Peak-to-level comparator chain with decay and thermometer bar.
// Purely combinational; the top registers its outputs.
module level_encoder
  import audio_pkg::*;
#(
  parameter int MAG_W       = 11,
  parameter int THRESH_STEP = THRESH_STEP_DEF
) (
  input  logic [MAG_W-1:0] peak,
  input  logic [LVL_W-1:0] cur_level,
  output logic [LVL_W-1:0] next_level,
  output logic [LEVELS-1:0] bar
);

  logic [LVL_W-1:0] raw_level;

  always_comb begin
    raw_level = '0;
    for (int k = 1; k <= LEVELS; k++) begin
      if (32'(peak) >= k * THRESH_STEP)
        raw_level = raw_level + 4'd1;
    end
  end

  // Rise instantly, fall one step per window.
  always_comb begin
    next_level = raw_level;
    if (raw_level < cur_level)
      next_level = cur_level - 4'd1;
  end

  always_comb begin
    bar = '0;
    for (int i = 0; i < LEVELS; i++)
      bar[i] = (next_level > LVL_W'(i));
  end

endmodule

// File: rtl/audio_level_meter.sv
// Windowed peak meter driving a 9-segment LED bar.
// Tracks |sample-mid| peak per window, then publishes a decaying level.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = 12,
  parameter int MIDPOINT    = MIDPOINT_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int THRESH_STEP = THRESH_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [8:0]          led_audio_out,
  output logic [3:0]          level,
  output logic                level_valid
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam int MAG_W = SAMPLE_W - 1;

  localparam logic [SAMPLE_W-1:0] MID_C = SAMPLE_W'(MIDPOINT);
  localparam logic [SAMPLE_W-1:0] MAG_MAX = {1'b0, {MAG_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [0:0]          state;
  logic [CNT_W-1:0]    sample_cnt;
  logic [MAG_W-1:0]    peak;
  logic [MAG_W-1:0]    peak_nxt;
  logic [SAMPLE_W-1:0] diff;
  logic [MAG_W-1:0]    mag;
  logic [LVL_W-1:0]    next_level;
  logic [LEVELS-1:0]   next_bar;

  always_comb begin
    diff = '0;
    if (sample >= MID_C)
      diff = sample - MID_C;
    else
      diff = MID_C - sample;
    mag = (diff > MAG_MAX) ? MAG_MAX[MAG_W-1:0] : diff[MAG_W-1:0];
  end

  assign peak_nxt = (mag > peak) ? mag : peak;

  level_encoder #(
    .MAG_W      (MAG_W),
    .THRESH_STEP(THRESH_STEP)
  ) u_enc (
    .peak      (peak),
    .cur_level (level),
    .next_level(next_level),
    .bar       (next_bar)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_ACCUM;
      sample_cnt    <= '0;
      peak          <= '0;
      level         <= '0;
      led_audio_out <= '0;
      level_valid   <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      unique case (1'b1)
        (state == ST_ACCUM): begin
          if (sample_valid) begin
            peak <= peak_nxt;
            if (sample_cnt == CNT_LAST) begin
              sample_cnt <= '0;
              state      <= ST_UPDATE;
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end
        (state == ST_UPDATE): begin
          level         <= next_level;
          led_audio_out <= next_bar;
          level_valid   <= 1'b1;
          state         <= ST_ACCUM;
          // A strobe here opens the next window.
          if (sample_valid) begin
            sample_cnt <= CNT_W'(1);
            peak       <= mag;
          end else begin
            sample_cnt <= '0;
            peak       <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: randomized windows against a
// peak/decay reference model, with latency and pulse-count checks.
module tb_audio_level_meter;

  localparam int W = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic [8:0]  led_audio_out;
  logic [3:0]  level;
  logic        level_valid;

  audio_level_meter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .led_audio_out(led_audio_out),
    .level        (level),
    .level_valid  (level_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0;
  int n_fail = 0;
  int disp_m = 0;
  int last_cyc = 0;
  int first_cyc = 0;

  logic [11:0] win_q[$];
  int ev_lvl[$];
  int ev_led[$];
  int ev_cyc[$];

  always @(negedge clk) begin
    if (rst_n && level_valid) begin
      ev_lvl.push_back(int'(level));
      ev_led.push_back(int'(led_audio_out));
      ev_cyc.push_back(cyc);
    end
  end

  function automatic int mag_of(int s);
    int m;
    m = (s >= 2048) ? s - 2048 : 2048 - s;
    return (m > 2047) ? 2047 : m;
  endfunction

  function automatic int raw_of(int p);
    int r;
    r = p / 224;
    return (r > 9) ? 9 : r;
  endfunction

  function automatic int decay(int cur, int p);
    int r;
    r = raw_of(p);
    return (r >= cur) ? r : cur - 1;
  endfunction

  function automatic int bar_of(int l);
    return (1 << l) - 1;
  endfunction

  function automatic int q_peak();
    int p;
    p = 0;
    foreach (win_q[i])
      if (mag_of(int'(win_q[i])) > p) p = mag_of(int'(win_q[i]));
    return p;
  endfunction

  task automatic clear_ev();
    ev_lvl.delete();
    ev_led.delete();
    ev_cyc.delete();
  endtask

  task automatic fill_quiet(input int n, input int maxmag);
    for (int i = 0; i < n; i++)
      win_q.push_back(12'(2048 + $urandom_range(2 * maxmag) - maxmag));
  endtask

  task automatic drive(input int gap_pct);
    foreach (win_q[i]) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(posedge clk); #1;
        sample_valid = 1'b0;
        sample = 12'($urandom);
      end
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample = win_q[i];
      if (i == 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sample = 12'($urandom);
  endtask

  task automatic wait_pulse(output bit found, output int lvl,
                            output int led, output int lat,
                            output int cnt);
    found = 1'b0;
    lvl = -1;
    led = -1;
    lat = -1;
    for (int i = 0; i < 8 && ev_lvl.size() == 0; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    cnt = ev_lvl.size();
    if (cnt > 0) begin
      found = 1'b1;
      lvl = ev_lvl[0];
      led = ev_led[0];
      lat = ev_cyc[0] - last_cyc;
    end
    clear_ev();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_run++;
    if (level !== 4'd0 || led_audio_out !== 9'h000 || level_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: level=%0d led=%h lv=%b required 0/000/0",
               level, led_audio_out, level_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_run++;
    if (level !== 4'd0 || led_audio_out !== 9'h000 || level_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: level=%0d led=%h lv=%b required 0/000/0",
               level, led_audio_out, level_valid);
    end
    clear_ev();
    disp_m = 0;
  endtask

  task automatic test_silence();
    bit f;
    int l, d, lat, c;
    win_q.delete();
    for (int i = 0; i < W; i++) win_q.push_back(12'd2048);
    drive(5);
    wait_pulse(f, l, d, lat, c);
    disp_m = decay(disp_m, q_peak());
    n_run++;
    if (f !== 1'b1 || c !== 1) begin
      n_fail++;
      $display("FAIL silence_pulse: pulses=%0d required 1", c);
    end
    n_run++;
    if (l !== 0 || d !== 'h000 || l !== disp_m) begin
      n_fail++;
      $display("FAIL silence_level: level=%0d led=%h required 0/000", l, d);
    end
    n_run++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL silence_latency: got %0d required 2", lat);
    end
  endtask

  task automatic test_full_scale();
    bit f;
    int l, d, lat, c;
    win_q.delete();
    for (int i = 0; i < W - 1; i++) win_q.push_back(12'd2048);
    win_q.push_back(12'd4095);
    drive(0);
    wait_pulse(f, l, d, lat, c);
    disp_m = decay(disp_m, q_peak());
    n_run++;
    if (f !== 1'b1 || c !== 1 || lat !== 2) begin
      n_fail++;
      $display("FAIL full_scale_pulse: pulses=%0d lat=%0d required 1/2", c, lat);
    end
    n_run++;
    if (l !== 9 || d !== 'h1FF || l !== disp_m) begin
      n_fail++;
      $display("FAIL full_scale_level: level=%0d led=%h required 9/1ff", l, d);
    end
  endtask

  task automatic test_decay();
    bit f;
    int l, d, lat, c, exp_l;
    for (int w = 0; w < 10; w++) begin
      win_q.delete();
      fill_quiet(W, 223);
      drive(0);
      wait_pulse(f, l, d, lat, c);
      disp_m = decay(disp_m, q_peak());
      exp_l = (w < 9) ? 8 - w : 0;
      n_run++;
      if (f !== 1'b1 || l !== exp_l || l !== disp_m || d !== bar_of(exp_l)) begin
        n_fail++;
        $display("FAIL decay_w%0d: level=%0d led=%h required %0d/%h",
                 w, l, d, exp_l, bar_of(exp_l));
      end
    end
  endtask

  task automatic test_step();
    bit f;
    int l, d, lat, c, pos;
    win_q.delete();
    fill_quiet(W - 1, 100);
    pos = $urandom_range(W - 1);
    win_q.insert(pos, 12'd2720);
    drive(0);
    wait_pulse(f, l, d, lat, c);
    disp_m = decay(disp_m, q_peak());
    n_run++;
    if (f !== 1'b1 || l !== 3 || d !== 'h007 || l !== disp_m) begin
      n_fail++;
      $display("FAIL step_672: level=%0d led=%h required 3/007", l, d);
    end
    win_q.delete();
    fill_quiet(W - 1, 100);
    win_q.insert($urandom_range(W - 1), 12'd0);
    drive(0);
    wait_pulse(f, l, d, lat, c);
    disp_m = decay(disp_m, q_peak());
    n_run++;
    if (f !== 1'b1 || l !== 9 || d !== 'h1FF || l !== disp_m) begin
      n_fail++;
      $display("FAIL step_saturate: level=%0d led=%h required 9/1ff", l, d);
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    int l, d, lat, c;
    win_q.delete();
    fill_quiet(60, 50);
    win_q.push_back(12'd4095);
    fill_quiet(40, 50);
    drive(0);
    n_run++;
    if (level !== 4'd9) begin
      n_fail++;
      $display("FAIL reset_mid_pre: level=%0d required 9", level);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (level !== 4'd0 || led_audio_out !== 9'h000 || level_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: level=%0d led=%h lv=%b required 0/000/0",
               level, led_audio_out, level_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_ev();
    disp_m = 0;
    win_q.delete();
    fill_quiet(W, 200);
    drive(3);
    wait_pulse(f, l, d, lat, c);
    disp_m = decay(disp_m, q_peak());
    n_run++;
    if (f !== 1'b1 || c !== 1 || lat !== 2) begin
      n_fail++;
      $display("FAIL reset_mid_window: pulses=%0d lat=%0d required 1/2", c, lat);
    end
    n_run++;
    if (l !== 0 || d !== 'h000 || l !== disp_m) begin
      n_fail++;
      $display("FAIL reset_mid_level: level=%0d led=%h required 0/000", l, d);
    end
  endtask

  task automatic test_back_to_back();
    int pk[3];
    int exp_l[3];
    int amp, v, cur, n;
    win_q.delete();
    cur = disp_m;
    for (int w = 0; w < 3; w++) begin
      amp = $urandom_range(2047);
      pk[w] = 0;
      for (int i = 0; i < W; i++) begin
        v = 2048 + $urandom_range(2 * amp) - amp;
        if ($urandom_range(999) == 0) v = $urandom_range(4095);
        win_q.push_back(12'(v));
        if (mag_of(v) > pk[w]) pk[w] = mag_of(v);
      end
      cur = decay(cur, pk[w]);
      exp_l[w] = cur;
    end
    clear_ev();
    drive(0);
    repeat (6) @(negedge clk);
    n = ev_lvl.size();
    n_run++;
    if (n !== 3 || 3 * W !== win_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: windows=%0d required 3 (strobes %0d)",
               n, win_q.size());
    end
    if (n > 3) n = 3;
    for (int j = 0; j < n; j++) begin
      n_run++;
      if (ev_lvl[j] !== exp_l[j] || ev_led[j] !== bar_of(exp_l[j])) begin
        n_fail++;
        $display("FAIL b2b_level_%0d: level=%0d led=%h required %0d/%h",
                 j, ev_lvl[j], ev_led[j], exp_l[j], bar_of(exp_l[j]));
      end
      n_run++;
      if (ev_cyc[j] !== first_cyc + (j + 1) * W + 1) begin
        n_fail++;
        $display("FAIL b2b_timing_%0d: cycle=%0d required %0d",
                 j, ev_cyc[j], first_cyc + (j + 1) * W + 1);
      end
    end
    disp_m = cur;
    clear_ev();
  endtask

  initial begin
    test_reset();
    test_silence();
    test_full_scale();
    test_decay();
    test_step();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
